// File: rtl/mmu_pkg.sv
// Shared MMU definitions: PTE bit positions, page-table-walk responder state and PTE cache line.
package mmu_pkg;

  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_U = 4;
  localparam int unsigned PTE_A = 6;
  localparam int unsigned PTE_D = 7;

  // Widest address/PTE the cache line storage supports.
  localparam int unsigned MMU_XLEN = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemReq,
    StMemWait,
    StResp
  } ptw_resp_state_t;

  typedef struct packed {
    logic                valid;
    logic [MMU_XLEN-1:0] tag;
    logic [MMU_XLEN-1:0] data;
  } pte_cache_line_t;

  // Tag is the word address with the index bits stripped off.
  function automatic logic [MMU_XLEN-1:0] pte_tag(input logic [MMU_XLEN-1:0] addr,
                                                  input int unsigned idx_bits);
    return addr >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/ptw_pte_cache.sv
// Direct-mapped PTE cache, one PTE per line: combinational lookup, fill port,
// flush and store-snoop invalidation.
module ptw_pte_cache
  import mmu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENTRIES    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data,
  input  logic                  fill_en,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  flush,
  input  logic                  snoop_valid,
  input  logic [ADDR_WIDTH-1:0] snoop_addr
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  pte_cache_line_t lines_q [ENTRIES];

  logic [IDX_W-1:0]    lookup_idx, fill_idx, snoop_idx;
  logic [MMU_XLEN-1:0] lookup_tag, fill_tag, snoop_tag;
  logic                snoop_line_hit, snoop_kills_fill, snoop_kills_lookup;

  always_comb begin
    lookup_idx = lookup_addr[IDX_W+1:2];
    fill_idx   = fill_addr[IDX_W+1:2];
    snoop_idx  = snoop_addr[IDX_W+1:2];
    lookup_tag = pte_tag(MMU_XLEN'(lookup_addr), IDX_W);
    fill_tag   = pte_tag(MMU_XLEN'(fill_addr), IDX_W);
    snoop_tag  = pte_tag(MMU_XLEN'(snoop_addr), IDX_W);

    snoop_line_hit = snoop_valid && lines_q[snoop_idx].valid &&
                     (lines_q[snoop_idx].tag == snoop_tag);
    snoop_kills_fill   = snoop_valid && (snoop_idx == fill_idx) && (snoop_tag == fill_tag);
    snoop_kills_lookup = snoop_valid && (snoop_idx == lookup_idx) && (snoop_tag == lookup_tag);

    // A line being invalidated this cycle must not be reported as a hit.
    lookup_hit  = lines_q[lookup_idx].valid && (lines_q[lookup_idx].tag == lookup_tag) &&
                  !flush && !snoop_kills_lookup;
    lookup_data = DATA_WIDTH'(lines_q[lookup_idx].data);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        lines_q[i].valid <= 1'b0;
      end
    end else begin
      if (snoop_line_hit) begin
        lines_q[snoop_idx].valid <= 1'b0;
      end
      if (fill_en && !snoop_kills_fill) begin
        lines_q[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: MMU_XLEN'(fill_data)};
      end
    end
  end

endmodule

// File: rtl/ptw_responder.sv
// Page-table-walk responder: serves one PTE read at a time from the PTE cache or memory
// and returns it with a one-cycle ack. All outputs are registered.
module ptw_responder
  import mmu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned PTE_CACHE_ENTRIES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pt_walk_req,
  input  logic [ADDR_WIDTH-1:0] pt_walk_addr,
  output logic [DATA_WIDTH-1:0] pt_walk_data,
  output logic                  pt_walk_ack,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  input  logic                  flush,
  input  logic                  snoop_valid,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  output logic                  misalign_err
);

  ptw_resp_state_t       state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  lookup_hit;
  logic [DATA_WIDTH-1:0] lookup_data;
  logic                  fill_en;

  assign fill_en = (state == StMemWait) && mem_resp_valid;

  ptw_pte_cache #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (PTE_CACHE_ENTRIES)
  ) u_cache (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (addr_q),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .fill_en     (fill_en),
    .fill_addr   (addr_q),
    .fill_data   (mem_resp_data),
    .flush       (flush),
    .snoop_valid (snoop_valid),
    .snoop_addr  (snoop_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      addr_q        <= '0;
      pt_walk_data  <= '0;
      pt_walk_ack   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      misalign_err  <= 1'b0;
    end else begin
      // Ack, error and data are single-cycle; only the transitions into StResp set them.
      pt_walk_ack  <= 1'b0;
      misalign_err <= 1'b0;
      pt_walk_data <= '0;
      unique case (state)
        StIdle: begin
          if (pt_walk_req) begin
            addr_q <= pt_walk_addr;
            state  <= StLookup;
          end
        end
        StLookup: begin
          if (addr_q[1:0] != 2'b00) begin
            misalign_err <= 1'b1;
            pt_walk_ack  <= 1'b1;
            state        <= StResp;
          end else if (lookup_hit) begin
            pt_walk_data <= lookup_data;
            pt_walk_ack  <= 1'b1;
            state        <= StResp;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {addr_q[ADDR_WIDTH-1:2], 2'b00};
            state         <= StMemReq;
          end
        end
        StMemReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= StMemWait;
          end
        end
        StMemWait: begin
          if (mem_resp_valid) begin
            pt_walk_data <= mem_resp_data;
            pt_walk_ack  <= 1'b1;
            state        <= StResp;
          end
        end
        StResp: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_responder.sv
// Self-checking bench for ptw_responder: directed walks from the test plan followed by
// randomized walks, snoops and flushes checked against a word-address cache model.
module tb_ptw_responder;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pt_walk_req;
  logic [31:0] pt_walk_addr;
  logic [31:0] pt_walk_data;
  logic        pt_walk_ack;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        flush;
  logic        snoop_valid;
  logic [31:0] snoop_addr;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;
  int walks_done = 0;
  int ack_total = 0;
  int ack_consec = 0;
  bit prev_ack = 1'b0;

  // Model: each line remembers the full word address it holds.
  bit          m_valid [N];
  logic [29:0] m_waddr [N];
  logic [31:0] m_data  [N];

  int          last_lat;
  logic [31:0] last_data;
  logic [31:0] last_memaddr;

  always #5 clk = ~clk;

  ptw_responder #(
    .DATA_WIDTH        (32),
    .ADDR_WIDTH        (32),
    .PTE_CACHE_ENTRIES (N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pt_walk_req    (pt_walk_req),
    .pt_walk_addr   (pt_walk_addr),
    .pt_walk_data   (pt_walk_data),
    .pt_walk_ack    (pt_walk_ack),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .flush          (flush),
    .snoop_valid    (snoop_valid),
    .snoop_addr     (snoop_addr),
    .misalign_err   (misalign_err)
  );

  always @(negedge clk) begin
    if (pt_walk_ack) ack_total++;
    if (pt_walk_ack && prev_ack) ack_consec++;
    prev_ack = pt_walk_ack;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(N); i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_flush();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_clear();
  endtask

  task automatic do_snoop(input logic [31:0] a);
    int idx;
    step();
    snoop_valid = 1'b1;
    snoop_addr  = a;
    step();
    snoop_valid = 1'b0;
    idx = int'((a >> 2) % N);
    if (m_valid[idx] && m_waddr[idx] == a[31:2]) m_valid[idx] = 1'b0;
  endtask

  // One walk: drives the request, plays the memory with the given ready/response waits and
  // compares latency, data, error pulse and memory traffic against the model.
  task automatic do_walk(input logic [31:0] addr, input logic [31:0] mdata, input int rdy_wait,
                         input int resp_wait, input bit flush_on_resp, input bit hold);
    int          idx, exp_lat, exp_memreq, cyc, wait_cnt, resp_cnt, memreq_cycles, n_mis;
    bit          aligned, hit, accept_pending, resp_pending, done, addr_moved;
    logic [31:0] exp_data, data_seen, first_req_addr;
    idx        = int'((addr >> 2) % N);
    aligned    = (addr[1:0] == 2'b00);
    hit        = aligned && m_valid[idx] && (m_waddr[idx] == addr[31:2]);
    exp_lat    = (!aligned || hit) ? 3 : 5 + rdy_wait + resp_wait;
    exp_data   = !aligned ? 32'h0 : (hit ? m_data[idx] : mdata);
    exp_memreq = (aligned && !hit) ? rdy_wait + 1 : 0;
    step();
    pt_walk_req  = 1'b1;
    pt_walk_addr = addr;
    cyc = 1; wait_cnt = rdy_wait; resp_cnt = 0; memreq_cycles = 0; n_mis = 0;
    accept_pending = 0; resp_pending = 0; done = 0; addr_moved = 0;
    data_seen = '0; first_req_addr = '0;
    while (!done && cyc < 64) begin
      step();
      cyc++;
      mem_resp_valid = 1'b0;
      flush          = 1'b0;
      if (accept_pending) begin
        accept_pending = 0;
        resp_pending   = 1;
        resp_cnt       = resp_wait;
      end
      if (resp_pending) begin
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mdata;
          flush          = flush_on_resp;
          resp_pending   = 0;
        end else begin
          resp_cnt--;
        end
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (memreq_cycles == 0) first_req_addr = mem_req_addr;
        else if (mem_req_addr !== first_req_addr) addr_moved = 1;
        memreq_cycles++;
        if (wait_cnt == 0) begin
          mem_req_ready  = 1'b1;
          accept_pending = 1;
        end else begin
          wait_cnt--;
        end
      end
      if (misalign_err) n_mis++;
      if (pt_walk_ack) begin
        done      = 1;
        data_seen = pt_walk_data;
      end
    end
    if (!hold || !done) pt_walk_req = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    flush          = 1'b0;
    last_lat     = done ? cyc : 0;
    last_data    = data_seen;
    last_memaddr = first_req_addr;
    check("walk_latency", last_lat, exp_lat);
    check("walk_data", data_seen, exp_data);
    check("walk_misalign", n_mis, aligned ? 0 : 1);
    check("walk_memreq_cycles", memreq_cycles, exp_memreq);
    check("walk_memaddr_stable", addr_moved, 0);
    if (exp_memreq != 0) check("walk_memaddr", first_req_addr, {addr[31:2], 2'b00});
    if (aligned && !hit) begin
      if (flush_on_resp) begin
        model_clear();
      end else begin
        m_valid[idx] = 1'b1;
        m_waddr[idx] = addr[31:2];
        m_data[idx]  = mdata;
      end
    end
    walks_done++;
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; pt_walk_req = 1'b0; pt_walk_addr = '0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0; flush = 1'b0; snoop_valid = 1'b0;
    snoop_addr = '0;
    model_clear();
    step();
    step();
    rst = 1'b0;
    check("rst_ack", pt_walk_ack, 0);
    check("rst_data", pt_walk_data, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_mem_addr", mem_req_addr, 0);

    // Cold miss, then hit on the same address.
    do_walk(32'h0000_1004, 32'h2000_0C01, 0, 0, 0, 0);
    check("cold_lat5", last_lat, 5);
    check("cold_memaddr", last_memaddr, 32'h0000_1004);
    check("cold_data", last_data, 32'h2000_0C01);
    do_walk(32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check("hit_lat3", last_lat, 3);
    check("hit_data", last_data, 32'h2000_0C01);

    // Back-to-back: req held across the ack while the address moves to 0x2008.
    do_walk(32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 1);
    pt_walk_addr = 32'h0000_2008;
    do_walk(32'h0000_2008, 32'h1234_5001, 0, 0, 0, 0);
    check("b2b_memaddr", last_memaddr, 32'h0000_2008);

    // Misaligned request.
    do_walk(32'h0000_1006, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check("misalign_data", last_data, 0);

    // Flush during the fill still returns data; next access misses.
    do_flush();
    do_walk(32'h0000_1004, 32'h2000_0C01, 1, 1, 1, 0);
    check("flushfill_data", last_data, 32'h2000_0C01);
    do_walk(32'h0000_1004, 32'h2000_0C01, 0, 0, 0, 0);
    check("after_flush_miss", last_lat, 5);
    do_snoop(32'h0000_1008);
    do_walk(32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check("snoop_other_hit", last_lat, 3);
    do_snoop(32'h0000_1004);
    do_walk(32'h0000_1004, 32'h2000_0C05, 0, 0, 0, 0);
    check("snoop_match_miss", last_lat, 5);

    // Reset in MEM_WAIT, then a stray response.
    step();
    pt_walk_req = 1'b1; pt_walk_addr = 32'h0000_3000;
    step();
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    pt_walk_req = 1'b0;
    step();
    rst = 1'b0;
    model_clear();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBAD0_0001;
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rstmid_ack", pt_walk_ack, 0);
      check("rstmid_outs", {pt_walk_data | mem_req_addr}, 0);
      check("rstmid_valid", {mem_req_valid, misalign_err}, 0);
      step();
    end
    do_walk(32'h0000_3000, 32'h0000_3C01, 0, 0, 0, 0);
    check("rstmid_recover_lat", last_lat, 5);

    // Randomized walks with occasional snoops and flushes.
    for (int i = 0; i < 80; i++) begin
      a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      case ($urandom_range(0, 9))
        0: do_snoop(32'h0000_1000 + 32'(4 * $urandom_range(0, 11)));
        1: do_flush();
        default: ;
      endcase
      do_walk(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 9) == 0), 0);
    end

    step();
    step();
    check("ack_total", ack_total, walks_done);
    check("ack_consecutive", ack_consec, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
